exec_unit: RTL and testbench

Single-issue execute/write-back sequencer for the 8-bit computer. It accepts one 16-bit instruction at a time over a valid/ready handshake and drives the 16×8 register bank's two read ports. It captures the operands, computes the ALU result (including a multi-cycle shift-add multiply), and drives the bank's write port for exactly one cycle. It sits directly between instruction fetch and `reg_bank`.

---
 rtl/exec_unit.sv | 176 +++++++++++++++++
 tb/tb_exec_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute/write-back sequencer for the 8-bit computer: accepts one instruction,
// reads two bank operands, computes (shift-add MUL included) and writes back once.
module exec_unit #(
  parameter int ENABLE_MUL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  r_add_1,
  output logic [3:0]  r_add_2,
  input  logic [7:0]  data_1,
  input  logic [7:0]  data_2,
  output logic        w_r,
  output logic [3:0]  w_add,
  output logic [7:0]  w_data,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  flags,
  output logic        busy
);

  localparam int   DATA_W = 8;
  localparam logic MUL_ON = (ENABLE_MUL != 0);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

  state_t              state_q, state_d;
  logic [3:0]          opcode_q, rd_q;
  logic [DATA_W-1:0]   imm_q, op_a_q, op_b_q;
  logic                wr_q, ill_q;
  logic [2:0]          mul_cnt_q;
  logic [2*DATA_W-1:0] mul_acc_q, mul_acc_d;

  logic [DATA_W:0]     alu_out;
  logic [DATA_W-1:0]   ex_res;
  logic                ex_c, ex_write, ex_flags, ex_ill, ex_mul;

  // Returns {carry/borrow/shifted-out bit, result}.
  function automatic logic [DATA_W:0] alu(input logic [3:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] sh;
    sh  = '0;
    alu = '0;
    case (op)
      4'h1:       alu = {1'b0, a} + {1'b0, b};
      4'h2, 4'hA: alu = {1'b0, a} - {1'b0, b};
      4'h3:       alu = {1'b0, a & b};
      4'h4:       alu = {1'b0, a | b};
      4'h5:       alu = {1'b0, a ^ b};
      4'h6: begin
        sh  = {8'h00, a} << b[2:0];
        alu = {sh[8], sh[7:0]};
      end
      4'h7: begin
        sh  = {a, 8'h00} >> b[2:0];
        alu = {sh[7], sh[15:8]};
      end
      default:    alu = '0;
    endcase
  endfunction

  always_comb begin
    ex_write = 1'b0;
    ex_flags = 1'b0;
    ex_ill   = 1'b0;
    ex_mul   = 1'b0;
    alu_out  = alu(opcode_q, op_a_q, op_b_q);
    ex_res   = alu_out[DATA_W-1:0];
    ex_c     = alu_out[DATA_W];
    case (opcode_q)
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        ex_write = 1'b1;
        ex_flags = 1'b1;
      end
      4'h8: begin
        if (MUL_ON) ex_mul = 1'b1;
        else        ex_ill = 1'b1;
        ex_write = MUL_ON;
      end
      4'h9: begin
        ex_write = 1'b1;
        ex_res   = imm_q;
      end
      4'hA:    ex_flags = 1'b1;
      default: ex_ill   = 1'b1;
    endcase
  end

  // One multiplier bit per MUL cycle, LSB first.
  assign mul_acc_d = mul_acc_q +
                     (op_b_q[mul_cnt_q] ? ({8'h00, op_a_q} << mul_cnt_q) : 16'h0000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = ex_mul ? S_MUL : S_WB;
      S_MUL:   if (mul_cnt_q == 3'd7) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) begin
      opcode_q <= in_instr[15:12];
      rd_q     <= in_instr[11:8];
      imm_q    <= in_instr[7:0];
    end
    if (state_q == S_READ) begin
      op_a_q <= data_1;
      op_b_q <= data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_add_1   <= '0;
      r_add_2   <= '0;
      w_add     <= '0;
      w_data    <= '0;
      flags     <= '0;
      wr_q      <= 1'b0;
      ill_q     <= 1'b0;
      mul_cnt_q <= '0;
      mul_acc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          r_add_1 <= in_instr[7:4];
          r_add_2 <= in_instr[3:0];
        end
        S_EXEC: begin
          wr_q      <= ex_write;
          ill_q     <= ex_ill;
          mul_cnt_q <= '0;
          mul_acc_q <= '0;
          if (!ex_mul) begin
            if (ex_write) begin
              w_add  <= rd_q;
              w_data <= ex_res;
            end
            if (ex_flags) flags <= {ex_res[7], ex_c, (ex_res == 8'h00)};
          end
        end
        S_MUL: begin
          mul_acc_q <= mul_acc_d;
          mul_cnt_q <= mul_cnt_q + 3'd1;
          if (mul_cnt_q == 3'd7) begin
            w_add  <= rd_q;
            w_data <= mul_acc_d[7:0];
            flags  <= {mul_acc_d[7], (mul_acc_d[15:8] != 8'h00), (mul_acc_d[7:0] == 8'h00)};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_WB);
  assign w_r      = (state_q == S_WB) && wr_q;
  assign illegal  = (state_q == S_WB) && ill_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 16x8 register bank; a second
// instance built with ENABLE_MUL=0 covers the MUL-disabled decode.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_valid_b;
  logic [15:0] in_instr;
  logic        in_ready, w_r, done, illegal, busy;
  logic [3:0]  r_add_1, r_add_2, w_add;
  logic [7:0]  data_1, data_2, w_data;
  logic [2:0]  flags;
  logic        in_ready_b, w_r_b, done_b, illegal_b, busy_b;
  logic [3:0]  r_add_1_b, r_add_2_b, w_add_b;
  logic [7:0]  data_1_b, data_2_b, w_data_b;
  logic [2:0]  flags_b;

  logic [7:0] bank [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) if (w_r) bank[w_add] <= w_data;
  assign data_1   = bank[r_add_1];
  assign data_2   = bank[r_add_2];
  assign data_1_b = bank[r_add_1_b];
  assign data_2_b = bank[r_add_2_b];

  exec_unit #(.ENABLE_MUL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .r_add_1(r_add_1), .r_add_2(r_add_2), .data_1(data_1), .data_2(data_2),
    .w_r(w_r), .w_add(w_add), .w_data(w_data), .done(done), .illegal(illegal),
    .flags(flags), .busy(busy));

  exec_unit #(.ENABLE_MUL(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_instr(in_instr), .in_ready(in_ready_b),
    .r_add_1(r_add_1_b), .r_add_2(r_add_2_b), .data_1(data_1_b), .data_2(data_2_b),
    .w_r(w_r_b), .w_add(w_add_b), .w_data(w_data_b), .done(done_b), .illegal(illegal_b),
    .flags(flags_b), .busy(busy_b));

  int n_checks = 0;
  int n_fail   = 0;

  int         r_done_cyc, r_wr_cyc, r_wr_cnt, r_done_cnt, r_ill_cnt;
  logic       r_ill_at_done, r_rdy_after;
  logic [3:0] r_wa;
  logic [7:0] r_wd;
  logic [2:0] r_fl;

  // Issue one instruction on the main DUT and record what it does until the cycle after done.
  task automatic run_instr(input logic [15:0] instr);
    int g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    in_valid = 1'b1; in_instr = instr;
    r_done_cyc = -1; r_wr_cyc = -1; r_wr_cnt = 0; r_done_cnt = 0; r_ill_cnt = 0;
    r_ill_at_done = 1'b0; r_rdy_after = 1'b0; r_wa = '0; r_wd = '0; r_fl = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (w_r) begin r_wr_cnt++; r_wr_cyc = k; r_wa = w_add; r_wd = w_data; end
      if (illegal) r_ill_cnt++;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin r_done_cyc = k; r_fl = flags; r_ill_at_done = illegal; end
      end
      if (r_done_cyc > 0 && k == r_done_cyc + 1) begin r_rdy_after = in_ready; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; in_instr = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({w_r, done, illegal, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {w_r, done, illegal, busy}); end
    n_checks++; if ({r_add_1, r_add_2, w_add, w_data} !== 20'h0) begin n_fail++; $display("FAIL reset_regs got=%h exp=00000", {r_add_1, r_add_2, w_add, w_data}); end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_ldi_add();
    run_instr(16'h91F0);
    n_checks++; if (r_wr_cyc !== 3 || r_wr_cnt !== 1) begin n_fail++; $display("FAIL ldi1_wr_timing cyc=%0d cnt=%0d exp cyc=3 cnt=1", r_wr_cyc, r_wr_cnt); end
    n_checks++; if ({r_wa, r_wd} !== {4'h1, 8'hF0}) begin n_fail++; $display("FAIL ldi1_write got=%h/%h exp=1/f0", r_wa, r_wd); end
    n_checks++; if (r_done_cyc !== 3 || r_rdy_after !== 1'b1) begin n_fail++; $display("FAIL ldi1_latency done=%0d rdy=%b exp 3/1", r_done_cyc, r_rdy_after); end
    run_instr(16'h9220);
    n_checks++; if (r_wr_cyc !== 3 || {r_wa, r_wd} !== {4'h2, 8'h20}) begin n_fail++; $display("FAIL ldi2_write cyc=%0d got=%h/%h exp 3 2/20", r_wr_cyc, r_wa, r_wd); end
    run_instr(16'h1312);
    n_checks++; if ({r_wa, r_wd} !== {4'h3, 8'h10}) begin n_fail++; $display("FAIL add_write got=%h/%h exp=3/10", r_wa, r_wd); end
    n_checks++; if (r_fl !== 3'b010) begin n_fail++; $display("FAIL add_flags got=%b exp=010", r_fl); end
  endtask

  task automatic test_sub_cmp_shift();
    run_instr(16'h2421);
    n_checks++; if ({r_wa, r_wd} !== {4'h4, 8'h30} || r_fl !== 3'b010) begin n_fail++; $display("FAIL sub got=%h/%h fl=%b exp=4/30 fl=010", r_wa, r_wd, r_fl); end
    run_instr(16'hA011);
    n_checks++; if (r_wr_cnt !== 0) begin n_fail++; $display("FAIL cmp_no_write got=%0d exp=0", r_wr_cnt); end
    n_checks++; if (r_fl !== 3'b001) begin n_fail++; $display("FAIL cmp_flags got=%b exp=001", r_fl); end
    run_instr(16'h6512);
    n_checks++; if (r_wd !== 8'hF0 || r_fl !== 3'b100) begin n_fail++; $display("FAIL shl0 got=%h fl=%b exp=f0 fl=100", r_wd, r_fl); end
    run_instr(16'h9603);
    run_instr(16'h7516);
    n_checks++; if ({r_wa, r_wd} !== {4'h5, 8'h1E} || r_fl !== 3'b000) begin n_fail++; $display("FAIL shr3 got=%h/%h fl=%b exp=5/1e fl=000", r_wa, r_wd, r_fl); end
  endtask

  task automatic test_mul();
    run_instr(16'h910F);
    run_instr(16'h9211);
    run_instr(16'h8712);
    n_checks++; if (r_done_cyc !== 11 || r_wr_cyc !== 11) begin n_fail++; $display("FAIL mul_latency done=%0d wr=%0d exp=11/11", r_done_cyc, r_wr_cyc); end
    n_checks++; if ({r_wa, r_wd} !== {4'h7, 8'hFF} || r_fl !== 3'b100) begin n_fail++; $display("FAIL mul_0f_11 got=%h/%h fl=%b exp=7/ff fl=100", r_wa, r_wd, r_fl); end
    run_instr(16'h9110);
    run_instr(16'h9210);
    run_instr(16'h8712);
    n_checks++; if (r_wd !== 8'h00 || r_fl !== 3'b011 || r_wr_cnt !== 1) begin n_fail++; $display("FAIL mul_10_10 got=%h fl=%b wr=%0d exp=00 fl=011 wr=1", r_wd, r_fl, r_wr_cnt); end
  endtask

  task automatic test_mul_disabled();
    int dcyc = -1, wr = 0, ill = 0, coin = 0;
    in_valid_b = 1'b1; in_instr = 16'h8712;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) in_valid_b = 1'b0;
      if (w_r_b) wr++;
      if (illegal_b) ill++;
      if (illegal_b && done_b) coin++;
      if (done_b && dcyc < 0) dcyc = k;
    end
    n_checks++; if (ill !== 1 || coin !== 1) begin n_fail++; $display("FAIL nomul_illegal ill=%0d coincident=%0d exp=1/1", ill, coin); end
    n_checks++; if (wr !== 0 || dcyc !== 3) begin n_fail++; $display("FAIL nomul_nowrite wr=%0d done=%0d exp=0/3", wr, dcyc); end
  endtask

  task automatic test_illegal_nop();
    run_instr(16'hC123);
    n_checks++; if (r_ill_cnt !== 1 || r_done_cnt !== 1 || r_ill_at_done !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse ill=%0d done=%0d coin=%b exp=1/1/1", r_ill_cnt, r_done_cnt, r_ill_at_done); end
    n_checks++; if (r_wr_cnt !== 0 || r_fl !== 3'b011) begin n_fail++; $display("FAIL illegal_effect wr=%0d fl=%b exp=0 fl=011", r_wr_cnt, r_fl); end
    run_instr(16'h0000);
    n_checks++; if (r_done_cnt !== 1 || r_ill_cnt !== 0 || r_wr_cnt !== 0 || r_done_cyc !== 3) begin n_fail++; $display("FAIL nop done=%0d ill=%0d wr=%0d cyc=%0d exp=1/0/0/3", r_done_cnt, r_ill_cnt, r_wr_cnt, r_done_cyc); end
    n_checks++; if (r_fl !== 3'b011) begin n_fail++; $display("FAIL nop_flags got=%b exp=011", r_fl); end
  endtask

  task automatic test_back_to_back();
    int first_done = -1, dn = 0, wr = 0, ldi_wr = 0, ldi_cyc = -1;
    logic rdy12 = 1'b0;
    in_valid = 1'b1; in_instr = 16'h8712;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_instr = 16'h985A;
      if (k == 13) in_valid = 1'b0;
      if (k == 12) rdy12 = in_ready;
      if (done) begin dn++; if (first_done < 0) first_done = k; end
      if (w_r) wr++;
      if (w_r && w_add == 4'h8) begin ldi_wr++; ldi_cyc = k; end
    end
    n_checks++; if (first_done !== 11 || rdy12 !== 1'b1) begin n_fail++; $display("FAIL b2b_mul done=%0d rdy12=%b exp=11/1", first_done, rdy12); end
    n_checks++; if (ldi_wr !== 1 || ldi_cyc !== 15) begin n_fail++; $display("FAIL b2b_accept_once wr=%0d cyc=%0d exp=1/15", ldi_wr, ldi_cyc); end
    n_checks++; if (dn !== 2 || wr !== 2 || bank[8] !== 8'h5A) begin n_fail++; $display("FAIL b2b_totals done=%0d wr=%0d r8=%h exp=2/2/5a", dn, wr, bank[8]); end
  endtask

  task automatic test_reset_mid_op();
    int wr = 0, dn = 0;
    run_instr(16'h910F);
    run_instr(16'h9211);
    in_valid = 1'b1; in_instr = 16'h8712;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (w_r) wr++;
      if (done) dn++;
      if (k == 7) begin
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low got=%b exp=0", in_ready); end
      end
      if (k == 8) begin
        n_checks++; if (flags !== 3'b000 || busy !== 1'b0 || w_data !== 8'h00) begin n_fail++; $display("FAIL midrst_state fl=%b busy=%b wd=%h exp=000/0/00", flags, busy, w_data); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_release got=%b exp=1", in_ready); end
      end
    end
    n_checks++; if (wr !== 0 || dn !== 0) begin n_fail++; $display("FAIL midrst_discard wr=%0d done=%0d exp=0/0", wr, dn); end
    run_instr(16'h9977);
    n_checks++; if (r_done_cyc !== 3 || {r_wa, r_wd} !== {4'h9, 8'h77}) begin n_fail++; $display("FAIL midrst_fresh_ldi cyc=%0d got=%h/%h exp=3 9/77", r_done_cyc, r_wa, r_wd); end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_sub_cmp_shift();
    test_mul();
    test_mul_disabled();
    test_illegal_nop();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
